hazard_ctrl: RTL
================

# hazard_ctrl

Central stall/flush controller for the 8-stage RV64 pipeline (IF, IDR, IDC, EXA, EXB, MEMP, MEMR, WB). It consumes the forwarding unit's `no_forwarding_data` stall request, the EXB branch/jump redirect and the MEMP data-memory busy indication. From these it drives per-stage stall, flush and bubble controls plus the fetch redirect. It also latches a redirect that arrives during a memory wait and replays it, and keeps hazard performance and debug counters.

## Interface
- `STALL_LIMIT`, default 64: number of consecutive data-hazard stall cycles after which `hazard_timeout` is set.
- `clk`, input, 1: pipeline clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `no_forwarding_data`, input, 1: IDC operand not forwardable yet; stall request.
- `redirect_valid_EXB`, input, 1: EXB resolved a taken branch, a jump or a mispredict.
- `redirect_pc_EXB`, input, 64: target PC for that redirect.
- `mem_busy_MEMP`, input, 1: data memory not ready; MEMP must hold.
- `stall_IF`, `stall_IDR`, `stall_IDC`, output, 1 each: hold the stage register.
- `stall_EXA`, `stall_EXB`, `stall_MEMP`, output, 1 each: hold the stage register (memory wait only).
- `bubble_EXA`, output, 1: load a NOP into the EXA register (rf_wr_en=0, dm ctrl=0).
- `bubble_MEMR`, output, 1: load a NOP into the MEMR register.
- `flush_IF`, `flush_IDR`, `flush_IDC`, `flush_EXA`, output, 1 each: invalidate the stage register.
- `pc_redirect_valid`, output, 1: fetch takes `pc_redirect` this cycle.
- `pc_redirect`, output, 64: redirect target.
- `stall_cycles`, output, 32: saturating count of cycles in which `stall_IF` is 1.
- `hazard_timeout`, output, 1: sticky debug flag.
- `state_o`, output, 2: current FSM state, for debug.

## Operation
- FSM states: RUN=0, DHAZ=1, MEMWAIT=2, REPLAY=3.
- Priority within a cycle: memory wait > redirect > data hazard.
- Memory wait (`mem_busy_MEMP`=1, any state):
  - Combinationally assert all six stall outputs and `bubble_MEMR`.
  - No flush and no `pc_redirect_valid`.
  - Next state: MEMWAIT.
- Redirect in MEMWAIT:
  - A `redirect_valid_EXB` seen during MEMWAIT is latched into `pend_valid`/`pend_pc`. The first one is kept; later ones are ignored, because EXB is frozen.
- Leaving MEMWAIT (`mem_busy_MEMP`=0):
  - With `pend_valid`: go to REPLAY.
  - Otherwise: go to RUN.
- REPLAY (one cycle):
  - `pc_redirect_valid`=1, `pc_redirect`=`pend_pc`.
  - Assert `flush_IF`, `flush_IDR`, `flush_IDC`, `flush_EXA`.
  - Clear `pend_valid`. Next state: RUN.
  - If `mem_busy_MEMP` rises in this cycle, the memory wait wins: go to MEMWAIT and keep `pend_valid`.
- Redirect in RUN or DHAZ (no memory wait):
  - `pc_redirect_valid`=1, `pc_redirect`=`redirect_pc_EXB`, flush IF, IDR, IDC, EXA.
  - `no_forwarding_data` is ignored this cycle; the instruction in IDC is flushed.
  - Next state: RUN.
- Data hazard (`no_forwarding_data`=1, no memory wait, no redirect):
  - Assert `stall_IF`, `stall_IDR`, `stall_IDC` and `bubble_EXA`. Next state: DHAZ.
  - DHAZ stays while the request holds and returns to RUN when it drops.
- `dhaz_cnt`: increments each DHAZ stall cycle and resets to 0 on any cycle without a data-hazard stall. When it reaches `STALL_LIMIT`, set `hazard_timeout`, which clears only on reset.
- `stall_cycles`: +1 whenever `stall_IF`=1; saturates at 32'hFFFF_FFFF.
- Unlisted outputs are 0. `pc_redirect` is 0 when `pc_redirect_valid`=0.

## Timing
- All stall, flush, bubble and redirect outputs are combinational from the inputs and the current state. There is no added latency; the pipeline registers act on the same clock edge.
- A replayed redirect appears exactly 1 cycle after the first cycle with `mem_busy_MEMP`=0.
- Reset (asynchronous): state RUN, `pend_valid`=0, `pend_pc`=0, `dhaz_cnt`=0, `stall_cycles`=0, `hazard_timeout`=0, all outputs 0.
- Reset asserted mid-MEMWAIT discards the pending redirect.

## Structure
- Shared package `pipeline_pkg`:
  - `hazard_state_t` enum (RUN, DHAZ, MEMWAIT, REPLAY).
  - `XLEN=64`.
- Sub-module `sat_counter`, parameterised width, holding the `stall_cycles` counter and the `dhaz_cnt` counter. Everything else stays flat in `hazard_ctrl`.

## Test plan
- Data hazard for 3 cycles: `no_forwarding_data`=1 → `stall_IF`/`stall_IDR`/`stall_IDC`/`bubble_EXA`=1 for exactly 3 cycles, state DHAZ, `stall_cycles`=3, return to RUN.
- Redirect with simultaneous hazard: `redirect_valid_EXB`=1, `redirect_pc_EXB`=0x8000_0100, `no_forwarding_data`=1 → `pc_redirect_valid`=1, `pc_redirect`=0x8000_0100, four flushes, no stall.
- Memory wait 4 cycles, redirect to 0x8000_0200 in the 2nd cycle → all stalls plus `bubble_MEMR` for 4 cycles, no flush during the wait. One cycle after busy drops: REPLAY, `pc_redirect`=0x8000_0200, flushes asserted, then RUN.
- Replay interrupted: busy rises again in the REPLAY cycle → no redirect, state MEMWAIT. The replay fires after the second wait ends.
- `STALL_LIMIT`=4, hazard held for 6 cycles → `hazard_timeout`=1 after the 4th stall cycle, still 1 after release.
- `rst_n` low mid-MEMWAIT with a pending redirect → all outputs 0 asynchronously. After release, no redirect is ever issued.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and widths for the RV64 pipeline control logic.
package pipeline_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {RUN = 2'd0, DHAZ = 2'd1, MEMWAIT = 2'd2, REPLAY = 2'd3} hazard_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/bubble controller with redirect replay across memory waits.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            no_forwarding_data,
  input  logic            redirect_valid_EXB,
  input  logic [XLEN-1:0] redirect_pc_EXB,
  input  logic            mem_busy_MEMP,
  output logic            stall_IF,
  output logic            stall_IDR,
  output logic            stall_IDC,
  output logic            stall_EXA,
  output logic            stall_EXB,
  output logic            stall_MEMP,
  output logic            bubble_EXA,
  output logic            bubble_MEMR,
  output logic            flush_IF,
  output logic            flush_IDR,
  output logic            flush_IDC,
  output logic            flush_EXA,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect,
  output logic [31:0]     stall_cycles,
  output logic            hazard_timeout,
  output logic [1:0]      state_o
);
  localparam int DW = $clog2(STALL_LIMIT + 1);
  hazard_state_t state, state_nxt;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [DW-1:0]   dhaz_cnt;
  logic            mem, replay, go_replay, redir, dhaz, flush;
  // Every control is gated by rst_n so outputs drop to 0 as soon as reset asserts.
  always_comb begin
    mem       = rst_n && mem_busy_MEMP;
    replay    = rst_n && !mem_busy_MEMP && state == REPLAY;
    go_replay = rst_n && !mem_busy_MEMP && state == MEMWAIT && (pend_valid || redirect_valid_EXB);
    redir     = rst_n && !mem_busy_MEMP && redirect_valid_EXB && (state == RUN || state == DHAZ);
    dhaz      = rst_n && !mem_busy_MEMP && no_forwarding_data && !replay && !go_replay && !redir;
    flush     = replay || redir;
    state_nxt = mem ? MEMWAIT : go_replay ? REPLAY : dhaz ? DHAZ : RUN;
  end
  assign stall_IF          = mem || dhaz;
  assign stall_IDR         = mem || dhaz;
  assign stall_IDC         = mem || dhaz;
  assign stall_EXA         = mem;
  assign stall_EXB         = mem;
  assign stall_MEMP        = mem;
  assign bubble_EXA        = dhaz;
  assign bubble_MEMR       = mem;
  assign flush_IF          = flush;
  assign flush_IDR         = flush;
  assign flush_IDC         = flush;
  assign flush_EXA         = flush;
  assign pc_redirect_valid = flush;
  assign pc_redirect       = replay ? pend_pc : redir ? redirect_pc_EXB : '0;
  assign state_o           = state;
  // EXB is frozen while memory waits, so only the first redirect seen is real.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      pend_valid     <= 1'b0;
      pend_pc        <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (replay) pend_valid <= 1'b0;
      else if ((mem || state == MEMWAIT) && redirect_valid_EXB && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc_EXB;
      end
      if (dhaz && int'(dhaz_cnt) >= STALL_LIMIT - 1) hazard_timeout <= 1'b1;
    end
  end
  sat_counter #(.W(32)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(stall_IF), .q(stall_cycles)
  );
  sat_counter #(.W(DW)) u_dhaz_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!dhaz), .inc(dhaz), .q(dhaz_cnt)
  );
endmodule
